cnn_mem_responder: RTL and testbench

CNN_MEM_RESPONDER -- requirements
Module: cnn_mem_responder

---
 rtl/cnn_mem_responder.sv | 105 ++++++++++
 tb/tb_cnn_mem_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_mem_responder.sv
// Fixed-latency word memory responder: one request in flight, completion pulse after LATENCY wait cycles.
// Optional out-of-range flag port mem_err is built only when CNN_MEM_ERR_EN is defined.
module cnn_mem_responder #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [11:0] address,
  input  logic [15:0] to_memory,
  output logic [15:0] from_memory,
`ifdef CNN_MEM_ERR_EN
  output logic        mem_ready,
  output logic        mem_err
`else
  output logic        mem_ready
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_next;
  logic [3:0]  count, count_next;
  logic        op_wr;
  logic [11:0] addr_q;
  logic [15:0] data_q;
  logic        accept, enter_done;
  logic        cur_wr, cur_in_range;
  logic [11:0] cur_addr;
  logic [15:0] cur_data;
  logic [15:0] mem [DEPTH];

  // With LATENCY=0 completion happens on the accept edge itself, so the live inputs stand in for the latches.
  assign accept       = (state == IDLE) && (rd_req || wr_req);
  assign cur_wr       = (state == IDLE) ? wr_req    : op_wr;
  assign cur_addr     = (state == IDLE) ? address   : addr_q;
  assign cur_data     = (state == IDLE) ? to_memory : data_q;
  assign cur_in_range = ({1'b0, cur_addr} < 13'(DEPTH));

  assign mem_ready = (state == DONE);
`ifdef CNN_MEM_ERR_EN
  assign mem_err = (state == DONE) && !({1'b0, addr_q} < 13'(DEPTH));
`endif

  always_comb begin
    state_next = state;
    count_next = count;
    enter_done = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_next = DONE;
            enter_done = 1'b1;
          end else begin
            state_next = BUSY;
            count_next = 4'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        if (count == 4'd0) begin
          state_next = DONE;
          enter_done = 1'b1;
        end else begin
          count_next = count - 4'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      count       <= 4'd0;
      op_wr       <= 1'b0;
      addr_q      <= 12'h000;
      data_q      <= 16'h0000;
      from_memory <= 16'h0000;
    end else begin
      state <= state_next;
      count <= count_next;
      if (accept) begin
        op_wr  <= wr_req;
        addr_q <= address;
        data_q <= to_memory;
      end
      if (enter_done && !cur_wr)
        from_memory <= cur_in_range ? mem[cur_addr[AW-1:0]] : 16'h0000;
    end
  end

  // Storage has no reset; the rst gate keeps a zero-latency write from landing while reset is held.
  always_ff @(posedge clk) begin
    if (rst && enter_done && cur_wr && cur_in_range)
      mem[cur_addr[AW-1:0]] <= cur_data;
  end

endmodule

// File: tb/tb_cnn_mem_responder.sv
// Scoreboard bench for cnn_mem_responder: three instances with LATENCY 0, 2 and 3 (DEPTH 1024).
module tb_cnn_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req      [3];
  logic        wr_req      [3];
  logic [11:0] address     [3];
  logic [15:0] to_memory   [3];
  logic [15:0] from_memory [3];
  logic        mem_ready   [3];
`ifdef CNN_MEM_ERR_EN
  logic        mem_err     [3];
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] model     [3][4096];
  logic [15:0] last_read [3];
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  cnn_mem_responder #(.LATENCY(0), .DEPTH(1024)) u_lat0 (
    .clk(clk), .rst(rst), .rd_req(rd_req[0]), .wr_req(wr_req[0]),
    .address(address[0]), .to_memory(to_memory[0]), .from_memory(from_memory[0]),
`ifdef CNN_MEM_ERR_EN
    .mem_err(mem_err[0]),
`endif
    .mem_ready(mem_ready[0]));

  cnn_mem_responder #(.LATENCY(2), .DEPTH(1024)) u_lat2 (
    .clk(clk), .rst(rst), .rd_req(rd_req[1]), .wr_req(wr_req[1]),
    .address(address[1]), .to_memory(to_memory[1]), .from_memory(from_memory[1]),
`ifdef CNN_MEM_ERR_EN
    .mem_err(mem_err[1]),
`endif
    .mem_ready(mem_ready[1]));

  cnn_mem_responder #(.LATENCY(3), .DEPTH(1024)) u_lat3 (
    .clk(clk), .rst(rst), .rd_req(rd_req[2]), .wr_req(wr_req[2]),
    .address(address[2]), .to_memory(to_memory[2]), .from_memory(from_memory[2]),
`ifdef CNN_MEM_ERR_EN
    .mem_err(mem_err[2]),
`endif
    .mem_ready(mem_ready[2]));

  function automatic int lat(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
  endfunction

  // One complete transaction on instance i; expectations come from the bench model.
  task automatic do_req(input int i, input logic wr, input logic rd,
                        input logic [11:0] a, input logic [15:0] d, input string tag);
    int n;
    logic [15:0] exp;
    @(negedge clk);
    rd_req[i] = rd; wr_req[i] = wr; address[i] = a; to_memory[i] = d;
    if (wr) begin
      if (a < 12'd1024) model[i][a] = d;
    end else begin
      exp_q.push_back((a < 12'd1024) ? model[i][a] : 16'h0000);
    end
    @(posedge clk); #1;
    rd_req[i] = 1'b0; wr_req[i] = 1'b0; address[i] = ~a; to_memory[i] = ~d;
    n = 0;
    while (mem_ready[i] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != lat(i)) begin
      errors++;
      $display("[TB] FAIL %s latency: got %0d edges, expected %0d", tag, n, lat(i));
    end
    if (mem_ready[i] === 1'b1) begin
      if (!wr) begin
        exp = exp_q.pop_front();
        checks++;
        if (from_memory[i] !== exp) begin
          errors++;
          $display("[TB] FAIL %s read data: got %h, expected %h", tag, from_memory[i], exp);
        end
        last_read[i] = exp;
      end else begin
        checks++;
        if (from_memory[i] !== last_read[i]) begin
          errors++;
          $display("[TB] FAIL %s write hold: from_memory %h, expected %h", tag, from_memory[i], last_read[i]);
        end
      end
`ifdef CNN_MEM_ERR_EN
      checks++;
      if (mem_err[i] !== (a >= 12'd1024)) begin
        errors++;
        $display("[TB] FAIL %s mem_err: got %b, expected %b", tag, mem_err[i], (a >= 12'd1024));
      end
`endif
      @(posedge clk); #1;
      checks++;
      if (mem_ready[i] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s pulse width: mem_ready %b, expected 0", tag, mem_ready[i]);
      end
    end else if (!wr && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_req[i] = 1'b0; wr_req[i] = 1'b0; address[i] = 12'h000; to_memory[i] = 16'h0000;
      last_read[i] = 16'h0000;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_ready[i] !== 1'b0 || from_memory[i] !== 16'h0000) begin
        errors++;
        $display("[TB] FAIL reset inst%0d: ready %b data %h, expected 0 0000", i, mem_ready[i], from_memory[i]);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_write_read();
    do_req(1, 1'b1, 1'b0, 12'h010, 16'hBEEF, "lat2_write");
    do_req(1, 1'b0, 1'b1, 12'h010, 16'h0000, "lat2_read");
    for (int k = 0; k < 4; k++) begin
      logic [11:0] a;
      a = 12'($urandom_range(64, 1023));
      do_req(1, 1'b1, 1'b0, a, 16'($urandom), "lat2_rand_write");
      do_req(1, 1'b0, 1'b1, a, 16'h0000, "lat2_rand_read");
    end
  endtask

  task automatic test_zero_latency();
    do_req(0, 1'b1, 1'b0, 12'h005, 16'h1234, "lat0_write");
    do_req(0, 1'b0, 1'b1, 12'h005, 16'h0000, "lat0_read");
  endtask

  task automatic test_write_priority();
    do_req(1, 1'b1, 1'b1, 12'h020, 16'hA5A5, "prio_both");
    do_req(1, 1'b0, 1'b1, 12'h020, 16'h0000, "prio_read");
  endtask

  task automatic test_out_of_range();
    do_req(1, 1'b1, 1'b0, 12'h000, 16'h0F0F, "oor_base_write");
    do_req(1, 1'b1, 1'b0, 12'h400, 16'hDEAD, "oor_write");
    do_req(1, 1'b0, 1'b1, 12'h000, 16'h0000, "oor_alias_read");
    do_req(1, 1'b0, 1'b1, 12'h400, 16'h0000, "oor_read");
    do_req(1, 1'b0, 1'b1, 12'hFFF, 16'h0000, "oor_top_read");
  endtask

  task automatic test_reset_abort();
    do_req(2, 1'b1, 1'b0, 12'h030, 16'h1111, "abort_pre_write");
    do_req(2, 1'b0, 1'b1, 12'h030, 16'h0000, "abort_pre_read");
    @(negedge clk);
    wr_req[2] = 1'b1; address[2] = 12'h030; to_memory[2] = 16'h7777;
    @(posedge clk); #1;
    wr_req[2] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (mem_ready[2] !== 1'b0 || from_memory[2] !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL abort during reset: ready %b data %h, expected 0 0000", mem_ready[2], from_memory[2]);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) last_read[i] = 16'h0000;
    do_req(2, 1'b0, 1'b1, 12'h030, 16'h0000, "abort_post_read");
  endtask

  task automatic test_busy_toggle();
    int pulses;
    int first;
    logic [15:0] exp;
    pulses = 0;
    first = -1;
    @(negedge clk);
    rd_req[2] = 1'b1; address[2] = 12'h030;
    exp_q.push_back(model[2][12'h030]);
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      rd_req[2] = (k <= 4) ? ~rd_req[2] : 1'b0;
      @(posedge clk); #1;
      if (mem_ready[2] === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first = k;
          exp = exp_q.pop_front();
          checks++;
          if (from_memory[2] !== exp) begin
            errors++;
            $display("[TB] FAIL toggle read data: got %h, expected %h", from_memory[2], exp);
          end
        end
      end
    end
    if (first < 0 && exp_q.size() > 0) exp = exp_q.pop_front();
    checks++;
    if (pulses != 1 || first != 3) begin
      errors++;
      $display("[TB] FAIL toggle pulses: got %0d first at %0d, expected 1 at 3", pulses, first);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      logic [11:0] a;
      a = 12'($urandom_range(256, 1023));
      do_req(0, 1'b1, 1'b0, a, 16'($urandom), "b2b_write");
      do_req(0, 1'b0, 1'b1, a, 16'h0000, "b2b_read");
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 4096; j++)
        model[i][j] = 16'h0000;
    test_reset();
    test_write_read();
    test_zero_latency();
    test_write_priority();
    test_out_of_range();
    test_reset_abort();
    test_busy_toggle();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
